// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared types and RV32I decode constants for the ALU issue stage.
//   alu_op_t is the operation code consumed directly by the ALU.
//   XLEN defaults to the `XLEN macro (32 for RV32I) unless defined earlier.
`ifndef XLEN
`define XLEN 32
`endif

package alu_issue_pkg;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // funct3 (instr[14:12])
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // funct7 (instr[31:25])
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode.sv
// alu_decode
//   Purely combinational RV32I integer-ALU decode: turns an instruction plus
//   its PC and register read data into ALU operands and operation.
//   Ports:
//     instr_i        32    instruction word
//     pc_i           XLEN  PC of instr_i
//     rs1_i / rs2_i  XLEN  register read data
//     a_o / b_o      XLEN  ALU operands (zero when illegal)
//     op_o           alu_op_t (ALU_NOP when illegal)
//     rd_o           5     instr_i[11:7], always passed through
//     we_o           1     writeback enable (legal and rd != x0)
//     illegal_o      1     instruction not handled here
module alu_decode
   import alu_issue_pkg::*;
#(
   parameter int XLEN = `XLEN
) (
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic [XLEN-1:0] a_o,
   output logic [XLEN-1:0] b_o,
   output alu_op_t         op_o,
   output logic [4:0]      rd_o,
   output logic            we_o,
   output logic            illegal_o
);

   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic [XLEN-1:0] imm_i, imm_u, shamt_r, shamt_i;
   logic            unused_rs1_idx;

   assign opc = instr_i[6:0];
   assign f3  = instr_i[14:12];
   assign f7  = instr_i[31:25];

   // Size casts of signed values sign-extend (matters for XLEN > 32).
   assign imm_i   = XLEN'($signed(instr_i[31:20]));
   assign imm_u   = XLEN'($signed({instr_i[31:12], 12'b0}));
   assign shamt_r = XLEN'(rs2_i[4:0]);
   assign shamt_i = XLEN'(instr_i[24:20]);

   // Register index fields are resolved by the register file, not here.
   assign unused_rs1_idx = ^instr_i[19:15];

   always_comb begin
      a_o       = rs1_i;
      b_o       = rs2_i;
      op_o      = ALU_NOP;
      illegal_o = 1'b1;
      // All handled opcodes end in 2'b11, so a compressed/invalid low pair
      // falls through to the illegal default.
      case (opc)
         OPC_OP: begin
            if (f7 == F7_BASE) begin
               illegal_o = 1'b0;
               case (f3)
                  F3_ADD:  op_o = ALU_ADD;
                  F3_SLL:  begin op_o = ALU_SLL; b_o = shamt_r; end
                  F3_SLT:  op_o = ALU_SLT;
                  F3_SLTU: op_o = ALU_SLTU;
                  F3_XOR:  op_o = ALU_XOR;
                  F3_SR:   begin op_o = ALU_SRL; b_o = shamt_r; end
                  F3_OR:   op_o = ALU_OR;
                  default: op_o = ALU_AND;
               endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
               // SUB goes to the adder with the two's complement of rs2.
               illegal_o = 1'b0;
               op_o      = ALU_ADD;
               b_o       = ~rs2_i + XLEN'(1);
            end else if (f7 == F7_ALT && f3 == F3_SR) begin
               illegal_o = 1'b0;
               op_o      = ALU_SRA;
               b_o       = shamt_r;
            end
         end
         OPC_OP_IMM: begin
            illegal_o = 1'b0;
            b_o       = imm_i;
            case (f3)
               F3_ADD:  op_o = ALU_ADD;
               F3_SLT:  op_o = ALU_SLT;
               F3_SLTU: op_o = ALU_SLTU;
               F3_XOR:  op_o = ALU_XOR;
               F3_OR:   op_o = ALU_OR;
               F3_AND:  op_o = ALU_AND;
               F3_SLL: begin
                  b_o = shamt_i;
                  if (f7 == F7_BASE) op_o = ALU_SLL;
                  else               illegal_o = 1'b1;
               end
               default: begin
                  b_o = shamt_i;
                  if (f7 == F7_BASE)     op_o = ALU_SRL;
                  else if (f7 == F7_ALT) op_o = ALU_SRA;
                  else                   illegal_o = 1'b1;
               end
            endcase
         end
         OPC_LUI: begin
            illegal_o = 1'b0;
            op_o      = ALU_ADD;
            a_o       = '0;
            b_o       = imm_u;
         end
         OPC_AUIPC: begin
            illegal_o = 1'b0;
            op_o      = ALU_ADD;
            a_o       = pc_i;
            b_o       = imm_u;
         end
         default: ;
      endcase
      // Illegal instructions present clean all-zero operands and NOP.
      if (illegal_o) begin
         a_o  = '0;
         b_o  = '0;
         op_o = ALU_NOP;
      end
   end

   assign rd_o = instr_i[11:7];
   assign we_o = !illegal_o && (rd_o != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Issue stage in front of the integer ALU: decodes an RV32I instruction
//   and presents registered ALU operands through a valid/ready handshake.
//   One output register plus one skid entry give full throughput with a
//   registered in_ready (in_ready == skid empty).
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready        upstream handshake
//     in_instr, in_pc          instruction and its PC
//     in_rs1_data/in_rs2_data  register read data
//     flush                    drop everything held and incoming
//     out_valid/out_ready      downstream handshake
//     out_a/out_b/out_op       ALU operands and operation
//     out_rd/out_we            destination index and writeback enable
//     out_illegal              instruction not handled by this block
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int XLEN = `XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output alu_op_t         out_op,
   output logic [4:0]      out_rd,
   output logic            out_we,
   output logic            out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      alu_op_t         op;
      logic [4:0]      rd;
      logic            we;
      logic            illegal;
   } entry_t;

   entry_t dec, out_q, out_d, skid_q, skid_d;
   logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, in_rdy_q, in_rdy_d;
   logic   accept, drain;

   alu_decode #(.XLEN(XLEN)) u_dec (
      .instr_i   (in_instr),
      .pc_i      (in_pc),
      .rs1_i     (in_rs1_data),
      .rs2_i     (in_rs2_data),
      .a_o       (dec.a),
      .b_o       (dec.b),
      .op_o      (dec.op),
      .rd_o      (dec.rd),
      .we_o      (dec.we),
      .illegal_o (dec.illegal)
   );

   assign accept = in_valid && in_rdy_q;
   assign drain  = !out_vld_q || out_ready;

   always_comb begin
      out_d      = out_q;
      skid_d     = skid_q;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (drain) begin
         // accept and skid_vld_q are exclusive: in_ready is low while the
         // skid holds an entry, so the older skid entry always goes first.
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            out_d     = dec;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
      in_rdy_d = !skid_vld_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q      <= '0;
         skid_q     <= '0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         in_rdy_q   <= 1'b0;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         in_rdy_q   <= in_rdy_d;
      end
   end

   assign in_ready    = in_rdy_q;
   assign out_valid   = out_vld_q;
   assign out_a       = out_q.a;
   assign out_b       = out_q.b;
   assign out_op      = out_q.op;
   assign out_rd      = out_q.rd;
   assign out_we      = out_q.we;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Directed vectors with hand-computed expectations for alu_issue.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   at that same point, i.e. after the edge has settled.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, out_a, out_b;
   alu_op_t     out_op;
   logic [4:0]  out_rd;
   logic        out_we, out_illegal;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   alu_issue #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_op      (out_op),
      .out_rd      (out_rd),
      .out_we      (out_we),
      .out_illegal (out_illegal)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      in_valid    = 1'b1;
      in_instr    = ins;
      in_pc       = pc;
      in_rs1_data = rs1;
      in_rs2_data = rs2;
   endtask

   // Issue one instruction with out_ready=1 and check the presented entry.
   task automatic vec(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] ea, input logic [31:0] eb, input alu_op_t eop,
                      input logic [4:0] erd, input logic ewe, input logic eill);
      drive(ins, pc, rs1, rs2);
      tick();
      in_valid = 1'b0;
      check({tag, ".vld"}, out_valid, 1);
      check({tag, ".a"},   out_a,     ea);
      check({tag, ".b"},   out_b,     eb);
      check({tag, ".op"},  out_op,    eop);
      check({tag, ".rd"},  out_rd,    erd);
      check({tag, ".we"},  out_we,    ewe);
      check({tag, ".ill"}, out_illegal, eill);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
      tick(); tick();
      check("rst.in_ready", in_ready, 0);
      check("rst.out_valid", out_valid, 0);
      rst = 1'b0;
      check("rst.ready_lag", in_ready, 0);
      tick();
      check("post.in_ready", in_ready, 1);
      check("post.out_valid", out_valid, 0);
      check("post.a", out_a, 0);
      check("post.b", out_b, 0);
      check("post.op", out_op, ALU_NOP);
      check("post.rd", out_rd, 0);
      check("post.we", out_we, 0);
      check("post.ill", out_illegal, 0);

      // ---- decode vectors ----
      out_ready = 1'b1;
      vec("addi",   32'h00500093, 32'h0,   32'h0,        32'h0,        32'h0,        32'h5,        ALU_ADD,  5'd1, 1, 0);
      vec("sub",    32'h402081B3, 32'h0,   32'd10,       32'd3,        32'd10,       32'hFFFFFFFD, ALU_ADD,  5'd3, 1, 0);
      check("sub.result", 32'(out_a + out_b), 7);
      vec("srai",   32'h40435293, 32'h0,   32'h80000000, 32'h0,        32'h80000000, 32'h4,        ALU_SRA,  5'd5, 1, 0);
      vec("lui",    32'h12345137, 32'h0,   32'hFFFFFFFF, 32'h0,        32'h0,        32'h12345000, ALU_ADD,  5'd2, 1, 0);
      vec("auipc",  32'h00001297, 32'h100, 32'h0,        32'h0,        32'h100,      32'h1000,     ALU_ADD,  5'd5, 1, 0);
      vec("ecall",  32'h00000073, 32'h0,   32'h55,       32'h66,       32'h0,        32'h0,        ALU_NOP,  5'd0, 0, 1);
      vec("addi0",  32'h00100013, 32'h0,   32'h0,        32'h0,        32'h0,        32'h1,        ALU_ADD,  5'd0, 0, 0);
      vec("sll",    32'h00209233, 32'h0,   32'h7,        32'h123,      32'h7,        32'h3,        ALU_SLL,  5'd4, 1, 0);
      vec("badf7",  32'h40209233, 32'h0,   32'h7,        32'h123,      32'h0,        32'h0,        ALU_NOP,  5'd4, 0, 1);
      vec("badslli",32'h40109093, 32'h0,   32'h9,        32'h0,        32'h0,        32'h0,        ALU_NOP,  5'd1, 0, 1);
      vec("addim1", 32'hFFF00093, 32'h0,   32'h1,        32'h0,        32'h1,        32'hFFFFFFFF, ALU_ADD,  5'd1, 1, 0);
      vec("lowbits",32'h00500090, 32'h0,   32'h3,        32'h0,        32'h0,        32'h0,        ALU_NOP,  5'd1, 0, 1);
      vec("and",    32'h0020F3B3, 32'h0,   32'hF0F0,     32'hFF00,     32'hF0F0,     32'hFF00,     ALU_AND,  5'd7, 1, 0);
      vec("srl",    32'h0020D3B3, 32'h0,   32'h8,        32'h25,       32'h8,        32'h5,        ALU_SRL,  5'd7, 1, 0);
      vec("sra",    32'h4020D3B3, 32'h0,   32'h8,        32'hFFFFFFE3, 32'h8,        32'h3,        ALU_SRA,  5'd7, 1, 0);
      vec("slti",   32'hFFE0A413, 32'h0,   32'h1,        32'h0,        32'h1,        32'hFFFFFFFE, ALU_SLT,  5'd8, 1, 0);
      vec("srli",   32'h01F0D493, 32'h0,   32'h1,        32'h0,        32'h1,        32'd31,       ALU_SRL,  5'd9, 1, 0);
      vec("xor",    32'h0020C533, 32'h0,   32'hA,        32'h6,        32'hA,        32'h6,        ALU_XOR,  5'd10, 1, 0);
      tick();
      check("idle.out_valid", out_valid, 0);

      // ---- back-to-back throughput with out_ready=1 ----
      for (int i = 1; i <= 3; i++) begin
         drive(32'h00000013 | (i << 20) | ((10 + i) << 7), 0, 0, 0);
         tick();
         check("tput.vld", out_valid, 1);
         check("tput.rd", out_rd, 10 + i);
         check("tput.rdy", in_ready, 1);
      end
      in_valid = 1'b0;
      tick();

      // ---- backpressure: two accepted, third waits ----
      out_ready = 1'b0;
      drive(32'h00100093, 0, 0, 0);
      tick();
      check("bp.A.vld", out_valid, 1);
      check("bp.A.rd", out_rd, 1);
      check("bp.A.rdy", in_ready, 1);
      drive(32'h00200113, 0, 0, 0);
      tick();
      check("bp.B.rd", out_rd, 1);
      check("bp.B.rdy", in_ready, 0);
      drive(32'h00300193, 0, 0, 0);
      tick();
      check("bp.C.vld", out_valid, 1);
      check("bp.C.rd", out_rd, 1);
      check("bp.C.b", out_b, 1);
      check("bp.C.rdy", in_ready, 0);
      out_ready = 1'b1;
      tick();
      check("bp.d2.vld", out_valid, 1);
      check("bp.d2.rd", out_rd, 2);
      check("bp.d2.b", out_b, 2);
      check("bp.d2.rdy", in_ready, 1);
      tick();
      in_valid = 1'b0;
      check("bp.d3.vld", out_valid, 1);
      check("bp.d3.rd", out_rd, 3);
      check("bp.d3.b", out_b, 3);
      tick();
      check("bp.empty", out_valid, 0);

      // ---- flush with both entries full and a new input ----
      out_ready = 1'b0;
      drive(32'h00100093, 0, 0, 0);
      tick();
      drive(32'h00200113, 0, 0, 0);
      tick();
      check("fl.full", in_ready, 0);
      drive(32'h00300193, 0, 0, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl.vld", out_valid, 0);
      check("fl.rdy", in_ready, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fl.stale", out_valid, 0);
      end

      // ---- reset mid-transfer ----
      out_ready = 1'b0;
      drive(32'h00100093, 0, 32'h77, 0);
      tick();
      check("mr.a_pre", out_a, 32'h77);
      drive(32'h00200113, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("mr.rdy", in_ready, 0);
      check("mr.vld", out_valid, 0);
      rst = 1'b0;
      tick();
      check("mr.rdy2", in_ready, 1);
      check("mr.vld2", out_valid, 0);
      check("mr.a", out_a, 0);
      check("mr.rd", out_rd, 0);
      check("mr.op", out_op, ALU_NOP);
      out_ready = 1'b1;
      tick();
      check("mr.stale", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL expose parameter XLEN, default `XLEN, datapath width (32 for RV32I).
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  upstream instruction valid.
REQ-005 in_ready  out  1  block accepts the instruction this cycle.
REQ-006 in_instr  in  32  RV32I instruction word.
REQ-007 in_pc  in  XLEN  PC of in_instr.
REQ-008 in_rs1_data / in_rs2_data  in  XLEN  register-file read data for rs1/rs2.
REQ-009 flush  in  1  discard all held and incoming entries.
REQ-010 out_valid  out  1  ALU operands valid.
REQ-011 out_ready  in  1  downstream consumes the entry this cycle.
REQ-012 out_a / out_b  out  XLEN  ALU operands a, b.
REQ-013 out_op  out  alu_op_t  ALU operation.
REQ-014 out_rd  out  5  destination register index.
REQ-015 out_we  out  1  writeback enable.
REQ-016 out_illegal  out  1  instruction not handled by this block.

Function
REQ-017 Handshake: transfer on valid&&ready at both ports; out_* stable while out_valid&&!out_ready; out_valid never drops without transfer or flush.
REQ-018 Latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1 when the output stage is empty or draining.
REQ-019 Buffering: output register plus one skid entry; in_ready is registered and equals "skid entry empty"; sustained throughput 1/cycle with out_ready=1; strict in-order delivery, no loss, no duplication.
REQ-020 OP (0110011): funct7 0000000 maps funct3 000/001/010/011/100/101/110/111 to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; a=rs1_data, b=rs2_data.
REQ-021 OP funct7 0100000: funct3 000 is SUB, issued as op=ADD with b=(~rs2_data)+1 mod 2^XLEN; funct3 101 is SRA; any other funct3/funct7 combination is illegal.
REQ-022 Register shifts: b=zero-extended rs2_data[4:0].
REQ-023 OP-IMM (0010011): b=sign-extended imm[11:0]; SLLI requires funct7=0000000; SRLI/SRAI select on funct7 0000000/0100000 with b=zero-extended shamt[4:0]; any other shift funct7 is illegal.
REQ-024 LUI (0110111): op=ADD, a=0, b={imm[31:12],12'b0}; AUIPC (0010111): op=ADD, a=in_pc, b same.
REQ-025 Any other opcode, or in_instr[1:0]!=11: out_illegal=1, op=NOP, a=b=0, out_we=0.
REQ-026 out_we = !illegal && (rd!=0); out_rd = in_instr[11:7] in all cases.
REQ-027 flush: next cycle out_valid=0 and skid empty; flush wins over simultaneous in_valid&&in_ready (input dropped) and over out_ready.

Reset
REQ-028 While rst=1: in_ready=0 and out_valid=0; the cycle after rst deasserts in_ready=1.
REQ-029 After reset: out_a=out_b=0, out_op=NOP, out_rd=0, out_we=0, out_illegal=0, skid empty.
REQ-030 rst asserted mid-transfer discards all held entries; no entry appears after reset release.

Structure
REQ-031 alu_op_t stays in the shared typedef package; opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC) and funct3/funct7 constants SHALL be added to the shared defines/package.
REQ-032 Decode SHALL be a purely combinational sub-module alu_decode (instr, pc, rs1, rs2 -> a, b, op, rd, we, illegal); alu_issue holds the handshake and skid registers only.
REQ-033 out_* SHALL drive the existing ALU a/b/op ports directly with no further logic.

Verification
REQ-034 ADDI x1,x0,5 (0x00500093), rs1=0 -> next cycle a=0, b=5, op=ADD, rd=1, we=1, illegal=0.
REQ-035 SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> a=10, b=0xFFFFFFFD, op=ADD, rd=3; ALU result 7.
REQ-036 SRAI x5,x6,4 (0x40435293) -> op=SRA, b=4; LUI x2,0x12345 (0x12345137) -> a=0, b=0x12345000.
REQ-037 out_ready=0, present 3 back-to-back instructions -> 2 accepted, in_ready=0 while full; raise out_ready -> 2 delivered in order on consecutive cycles, third then accepted.
REQ-038 ECALL (0x00000073) -> illegal=1, op=NOP, we=0; ADDI x0,x0,1 (0x00100013) -> we=0, illegal=0.
REQ-039 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale entry ever emitted.
